mu0_mem_resp: RTL and testbench

MU0_MEM_RESP -- requirements
Module: mu0_mem_resp

---
 rtl/mu0_mem_resp.sv | 80 ++++++++
 tb/tb_mu0_mem_resp.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mu0_mem_resp.sv
// mu0_mem_resp: wait-stated single-port memory responder for the MU0 bus.
// Each request is latched in IDLE and completes WAIT+1 edges later with a one-cycle ready/err pulse.
module mu0_mem_resp #(
    parameter int MAXWIDTH = 16,
    parameter int MAXDEPTH = 12,
    parameter int MEMWORDS = 4096,
    parameter int WAIT     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Ren,
    input  logic                Wen,
    input  logic [MAXDEPTH-1:0] address,
    input  logic [MAXWIDTH-1:0] write_data,
    output logic [MAXWIDTH-1:0] read_data,
    output logic                ready,
    output logic                err
);
    localparam int AW = MEMWORDS > 1 ? $clog2(MEMWORDS) : 1;
    localparam logic [MAXDEPTH:0] LIM = MEMWORDS[MAXDEPTH:0];
    localparam logic [3:0] WAITV = WAIT[3:0];

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                r_state, w_next;
    logic [3:0]            r_cnt;
    logic [MAXDEPTH-1:0]   r_addr;
    logic [MAXWIDTH-1:0]   r_data;
    logic                  r_rd, r_wr;
    logic [MAXWIDTH-1:0]   r_mem [MEMWORDS];
    logic                  w_fire, w_oob, w_bad, w_we;
    logic [AW-1:0]         w_idx;

    // Out-of-range is judged on the latched address, so mid-access address changes are harmless.
    assign w_fire = (r_state == BUSY) && (r_cnt == 4'd0);
    assign w_oob  = {1'b0, r_addr} >= LIM;
    assign w_bad  = r_rd & r_wr;
    assign w_we   = w_fire & r_wr & ~r_rd & ~w_oob;
    assign w_idx  = r_addr[AW-1:0];

    always_comb begin
        w_next = (r_state == IDLE) ? ((Ren | Wen) ? BUSY : IDLE) :
                 (r_state == BUSY) ? (w_fire ? DONE : BUSY) : IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_addr    <= '0;
            r_data    <= '0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            ready     <= 1'b0;
            err       <= 1'b0;
            read_data <= '0;
        end else begin
            r_state <= w_next;
            ready   <= w_fire;
            err     <= w_fire & (w_bad | w_oob);
            if (r_state == IDLE && (Ren | Wen)) begin
                r_addr <= address;
                r_data <= write_data;
                r_rd   <= Ren;
                r_wr   <= Wen;
                r_cnt  <= WAITV;
            end else if (r_state == BUSY && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_fire && r_rd && !r_wr)
                read_data <= w_oob ? '0 : r_mem[w_idx];
        end
    end

    // Storage is deliberately left out of reset so contents survive an aborted access.
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_idx] <= r_data;
    end
endmodule

// File: tb/tb_mu0_mem_resp.sv
// tb_mu0_mem_resp: directed vector bench for mu0_mem_resp.
// Instance a: WAIT=2, MEMWORDS=256; instance b: WAIT=0, MEMWORDS=4096; sel picks the target.
module tb_mu0_mem_resp;
    logic        clk = 1'b0, rst_n = 1'b0, sel = 1'b0, ren = 1'b0, wen = 1'b0;
    logic [11:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rd_a, rd_b, rdata;
    logic        rdy_a, rdy_b, err_a, err_b, rdy, erro;
    int          tests = 0, fails = 0;

    typedef struct {
        logic        s, r, w;
        logic [11:0] a;
        logic [15:0] d;
        int          lat;
        logic        e;
        logic [15:0] rd;
    } vec_t;
    vec_t v[17];

    always #5 clk = ~clk;

    assign rdata = sel ? rd_b : rd_a;
    assign rdy   = sel ? rdy_b : rdy_a;
    assign erro  = sel ? err_b : err_a;

    mu0_mem_resp #(.MAXWIDTH(16), .MAXDEPTH(12), .MEMWORDS(256), .WAIT(2)) u_a (
        .clk(clk), .reset(rst_n), .Ren(ren & ~sel), .Wen(wen & ~sel), .address(addr),
        .write_data(wdata), .read_data(rd_a), .ready(rdy_a), .err(err_a));

    mu0_mem_resp #(.MAXWIDTH(16), .MAXDEPTH(12), .MEMWORDS(4096), .WAIT(0)) u_b (
        .clk(clk), .reset(rst_n), .Ren(ren & sel), .Wen(wen & sel), .address(addr),
        .write_data(wdata), .read_data(rd_b), .ready(rdy_b), .err(err_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic acc(input logic r, input logic w, input logic [11:0] a, input logic [15:0] d,
                       input logic chg, input logic [11:0] a2, input logic [15:0] d2,
                       output int lat, output logic e, output logic [15:0] rdv);
        @(negedge clk);
        ren = r; wen = w; addr = a; wdata = d;
        @(posedge clk); #1;
        lat = 0;
        if (chg) begin
            addr = a2; wdata = d2;
        end
        while (!rdy && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        e = erro; rdv = rdata;
        ren = 1'b0; wen = 1'b0;
        @(posedge clk); #1;
        check("done_clear", {30'd0, rdy, erro}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic        e;
        logic [15:0] rdv;
        logic [8:0]  pat;
        v[0]  = '{1'b0, 1'b0, 1'b1, 12'h005, 16'hBEEF, 3, 1'b0, 16'h0000};
        v[1]  = '{1'b0, 1'b1, 1'b0, 12'h005, 16'h0000, 3, 1'b0, 16'hBEEF};
        v[2]  = '{1'b0, 1'b0, 1'b1, 12'h0FF, 16'h7777, 3, 1'b0, 16'hBEEF};
        v[3]  = '{1'b0, 1'b1, 1'b0, 12'h100, 16'h0000, 3, 1'b1, 16'h0000};
        v[4]  = '{1'b0, 1'b0, 1'b1, 12'h100, 16'h1234, 3, 1'b1, 16'h0000};
        v[5]  = '{1'b0, 1'b1, 1'b0, 12'h0FF, 16'h0000, 3, 1'b0, 16'h7777};
        v[6]  = '{1'b0, 1'b0, 1'b1, 12'h010, 16'h0A0A, 3, 1'b0, 16'h7777};
        v[7]  = '{1'b0, 1'b1, 1'b1, 12'h010, 16'hFFFF, 3, 1'b1, 16'h7777};
        v[8]  = '{1'b0, 1'b1, 1'b0, 12'h010, 16'h0000, 3, 1'b0, 16'h0A0A};
        v[9]  = '{1'b0, 1'b0, 1'b1, 12'h020, 16'h3C3C, 3, 1'b0, 16'h0A0A};
        v[10] = '{1'b0, 1'b0, 1'b1, 12'h031, 16'h6666, 3, 1'b0, 16'h0A0A};
        v[11] = '{1'b1, 1'b0, 1'b1, 12'h000, 16'h1001, 1, 1'b0, 16'h0000};
        v[12] = '{1'b1, 1'b0, 1'b1, 12'h001, 16'h2002, 1, 1'b0, 16'h0000};
        v[13] = '{1'b1, 1'b1, 1'b0, 12'h000, 16'h0000, 1, 1'b0, 16'h1001};
        v[14] = '{1'b1, 1'b1, 1'b0, 12'h001, 16'h0000, 1, 1'b0, 16'h2002};
        v[15] = '{1'b1, 1'b0, 1'b1, 12'hFFF, 16'hABCD, 1, 1'b0, 16'h2002};
        v[16] = '{1'b1, 1'b1, 1'b0, 12'hFFF, 16'h0000, 1, 1'b0, 16'hABCD};

        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_a", {16'd0, rd_a}, 32'd0);
        check("rst_rd_b", {16'd0, rd_b}, 32'd0);
        check("rst_flags", {28'd0, rdy_a, err_a, rdy_b, err_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            sel = v[i].s;
            acc(v[i].r, v[i].w, v[i].a, v[i].d, 1'b0, 12'h0, 16'h0, lat, e, rdv);
            check($sformatf("v%0d_lat", i), lat, v[i].lat);
            check($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, v[i].e});
            check($sformatf("v%0d_rd", i), {16'd0, rdv}, {16'd0, v[i].rd});
        end

        sel = 1'b0;
        acc(1'b0, 1'b1, 12'h030, 16'h1111, 1'b1, 12'h031, 16'h2222, lat, e, rdv);
        check("chg_lat", lat, 3);
        check("chg_err", {31'd0, e}, 32'd0);
        acc(1'b1, 1'b0, 12'h030, 16'h0, 1'b0, 12'h0, 16'h0, lat, e, rdv);
        check("chg_rd030", {16'd0, rdv}, 32'h1111);
        acc(1'b1, 1'b0, 12'h031, 16'h0, 1'b0, 12'h0, 16'h0, lat, e, rdv);
        check("chg_rd031", {16'd0, rdv}, 32'h6666);

        sel = 1'b1;
        pat = 9'b010010010;
        @(negedge clk);
        ren = 1'b1; addr = 12'h000;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            check($sformatf("hold_rdy%0d", k), {31'd0, rdy}, {31'd0, pat[k]});
        end
        ren = 1'b0;
        check("hold_rd", {16'd0, rdata}, 32'h1001);

        sel = 1'b0;
        @(negedge clk);
        wen = 1'b1; addr = 12'h020; wdata = 16'h5555;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_a", {15'd0, rdy_a, err_a, rd_a}, 32'd0);
        check("abort_rd_b", {16'd0, rd_b}, 32'd0);
        wen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("abort_nordy%0d", k), {31'd0, rdy_a}, 32'd0);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        acc(1'b1, 1'b0, 12'h020, 16'h0, 1'b0, 12'h0, 16'h0, lat, e, rdv);
        check("abort_lat", lat, 3);
        check("abort_rd020", {16'd0, rdv}, 32'h3C3C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
